// File: rtl/mouse_link_pkg.sv
// Shared constants and FSM state type for the mouse-over-UART link.
// Frame layout: SYNC, STATUS, X, Y and, with MOUSE_TX_CHECKSUM_EN, CHK.
package mouse_link_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam logic [4:0] STATUS_FIXED     = 5'b00001;
    localparam int         FRAME_BYTES_BASE = 4;
    localparam int         FRAME_BYTES_CHK  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } tx_state_e;

    function automatic logic [7:0] status_byte(input logic middle, input logic right,
                                               input logic left);
        return {STATUS_FIXED, middle, right, left};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 byte serializer: bit-period counter plus 10-bit shifter.
// A start pulse in the final cycle of a stop bit chains the next byte with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       bit_tick,
    output logic       done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt;
    logic [3:0]       bit_cnt;
    logic             active;
    logic [9:0]       shreg;

    assign bit_tick = active && (clk_cnt == CNT_LAST);
    assign done     = bit_tick && (bit_cnt == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            tx      <= 1'b1;
        end else if (start) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            active  <= 1'b1;
            tx      <= 1'b0;
        end else if (bit_tick) begin
            clk_cnt <= '0;
            if (done) begin
                active <= 1'b0;
                tx     <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
                tx      <= shreg[1];
            end
        end else if (active) begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    // Shift register carries data only; the line level lives in tx.
    always_ff @(posedge clk) begin
        if (start) begin
            shreg <= {1'b1, data, 1'b0};
        end else if (bit_tick) begin
            shreg <= {1'b1, shreg[9:1]};
        end
    end

endmodule

// File: rtl/mouse_packet_uart_tx.sv
// Mouse packet to 8N1 UART serializer with a one-entry holding register.
// Define MOUSE_TX_CHECKSUM_EN to append CHK = STATUS ^ X ^ Y as a fifth byte.
module mouse_packet_uart_tx #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115200,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic signed [7:0] mouse_x,
    input  logic signed [7:0] mouse_y,
    input  logic              mouse_left,
    input  logic              mouse_right,
    input  logic              mouse_middle,
    output logic              uart_tx,
    output logic              busy
);
    import mouse_link_pkg::*;

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int GAP_CYCLES   = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W        = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef MOUSE_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES_CHK - 1);
`else
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES_BASE - 1);
`endif

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("mouse_packet_uart_tx: CLK_FREQ/BAUD must be at least 2");
    end

    tx_state_e         state_q, state_d;
    logic [2:0]        byte_idx;
    logic [2:0]        data_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              hold_full;
    logic              accept;
    logic signed [7:0] hold_x, hold_y;
    logic [2:0]        hold_btn;
    logic [7:0]        frm_status, frm_x, frm_y;
    logic [2:0]        tx_sel;
    logic [7:0]        tx_data;
    logic              byte_start, bit_tick, byte_done;

    assign accept    = pkt_valid && !hold_full;
    assign pkt_ready = !hold_full;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
        end else if (state_q == ST_LOAD) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_x   <= mouse_x;
            hold_y   <= mouse_y;
            hold_btn <= {mouse_middle, mouse_right, mouse_left};
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            frm_status <= status_byte(hold_btn[2], hold_btn[1], hold_btn[0]);
            frm_x      <= $unsigned(hold_x);
            frm_y      <= $unsigned(hold_y);
        end
    end

`ifdef MOUSE_TX_CHECKSUM_EN
    logic [7:0] frm_chk;

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            frm_chk <= status_byte(hold_btn[2], hold_btn[1], hold_btn[0])
                       ^ $unsigned(hold_x) ^ $unsigned(hold_y);
        end
    end
`endif

    // LOAD sends byte 0 while the frame register is still being written, so SYNC is a constant.
    always_comb begin
        tx_sel = (state_q == ST_LOAD) ? 3'd0 : byte_idx + 3'd1;
        case (tx_sel)
            3'd1:    tx_data = frm_status;
            3'd2:    tx_data = frm_x;
            3'd3:    tx_data = frm_y;
`ifdef MOUSE_TX_CHECKSUM_EN
            3'd4:    tx_data = frm_chk;
`endif
            default: tx_data = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A held packet goes straight from GAP to LOAD so it starts one cycle after the gap.
    always_comb begin
        state_d    = state_q;
        byte_start = 1'b0;
        case (state_q)
            ST_IDLE:  if (hold_full) state_d = ST_LOAD;
            ST_LOAD: begin
                byte_start = 1'b1;
                state_d    = ST_START;
            end
            ST_START: if (bit_tick) state_d = ST_DATA;
            ST_DATA:  if (bit_tick && data_cnt == 3'd7) state_d = ST_STOP;
            ST_STOP: begin
                if (byte_done) begin
                    if (byte_idx != LAST_BYTE) begin
                        byte_start = 1'b1;
                        state_d    = ST_START;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = hold_full ? ST_LOAD : ST_IDLE;
                    end
                end
            end
            ST_GAP:   if (gap_cnt == GAP_LAST) state_d = hold_full ? ST_LOAD : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
            data_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state_q)
                ST_LOAD:  byte_idx <= '0;
                ST_START: data_cnt <= '0;
                ST_DATA:  if (bit_tick) data_cnt <= data_cnt + 3'd1;
                ST_STOP: begin
                    if (byte_done) begin
                        gap_cnt <= '0;
                        if (byte_start) byte_idx <= byte_idx + 3'd1;
                    end
                end
                ST_GAP:   gap_cnt <= gap_cnt + 1'b1;
                default:  ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk     (clk),
        .reset   (reset),
        .start   (byte_start),
        .data    (tx_data),
        .tx      (uart_tx),
        .bit_tick(bit_tick),
        .done    (byte_done)
    );

endmodule

// File: tb/tb_mouse_packet_uart_tx.sv
// Bench for mouse_packet_uart_tx: a packet-level line model checked every cycle,
// an independent mid-bit UART decoder, and literal expectations for key packets.
module tb_mouse_packet_uart_tx;

    localparam int CPB  = 217;
    localparam int GAPB = 2;
`ifdef MOUSE_TX_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int LINE = NB * 10 * CPB;
    localparam int PLEN = LINE + GAPB * CPB;

    typedef struct packed {
        int          e;
        int          s;
        logic [39:0] by;
    } pkt_t;

    typedef struct packed {
        int         st;
        logic [7:0] b;
    } dec_t;

    logic       clk, reset, pkt_valid, pkt_ready;
    logic [7:0] mouse_x, mouse_y;
    logic       mouse_left, mouse_right, mouse_middle;
    logic       uart_tx, busy;

    int   ecnt   = 0;
    int   checks = 0;
    int   errors = 0;
    pkt_t sched[$];
    dec_t dq[$];
    int   last_g = -1000000;

    mouse_packet_uart_tx #(
        .CLK_FREQ(25_000_000),
        .BAUD    (115200),
        .GAP_BITS(GAPB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .mouse_x     (mouse_x),
        .mouse_y     (mouse_y),
        .mouse_left  (mouse_left),
        .mouse_right (mouse_right),
        .mouse_middle(mouse_middle),
        .uart_tx     (uart_tx),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, ecnt, act, exp);
        end
    endtask

    // Packet bytes from the button/delta fields; byte 0 in bits [7:0].
    function automatic logic [39:0] mk(input logic [7:0] x, input logic [7:0] y,
                                       input logic [2:0] btn);
        logic [7:0]  st;
        logic [39:0] r;
        st = {5'b00001, btn};
        r  = {8'h00, y, x, st, 8'hA5};
`ifdef MOUSE_TX_CHECKSUM_EN
        r[39:32] = st ^ x ^ y;
`endif
        return r;
    endfunction

    // Line model: each accepted packet owns a window of the line starting at s.
    logic etx, ebusy, erdy;
    pkt_t np;
    int   idx;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            sched.delete();
            last_g = -1000000;
        end else begin
            while (sched.size() > 0 && ecnt >= sched[0].s + PLEN) void'(sched.pop_front());
            etx   = 1'b1;
            ebusy = 1'b0;
            erdy  = 1'b1;
            foreach (sched[i]) begin
                if (ecnt >= sched[i].s - 1 && ecnt < sched[i].s + PLEN) ebusy = 1'b1;
                if (ecnt >= sched[i].e && ecnt < sched[i].s) erdy = 1'b0;
                if (ecnt >= sched[i].s && ecnt < sched[i].s + LINE) begin
                    idx = (ecnt - sched[i].s) / CPB;
                    if (idx % 10 == 0)      etx = 1'b0;
                    else if (idx % 10 == 9) etx = 1'b1;
                    else                    etx = sched[i].by[8 * (idx / 10) + (idx % 10) - 1];
                end
            end
            chk("uart_tx", uart_tx, etx);
            chk("busy", busy, ebusy);
            chk("pkt_ready", pkt_ready, erdy);
            if (pkt_valid === 1'b1 && erdy) begin
                np.e   = ecnt + 1;
                np.s   = (np.e + 2 > last_g + 1) ? np.e + 2 : last_g + 1;
                np.by  = mk(mouse_x, mouse_y, {mouse_middle, mouse_right, mouse_left});
                last_g = np.s + PLEN;
                sched.push_back(np);
            end
        end
    end

    // Independent decoder: find the falling edge, then sample each bit at its middle.
    dec_t d;
    initial begin : decoder
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && uart_tx === 1'b0) begin
                d.st = ecnt;
                d.b  = 8'h00;
                repeat (CPB / 2) @(negedge clk);
                if (uart_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        d.b[i] = uart_tx;
                    end
                    repeat (CPB) @(negedge clk);
                    dq.push_back(d);
                end
            end
        end
    end

    task automatic scramble_inputs();
        mouse_x      = 8'($urandom);
        mouse_y      = 8'($urandom);
        mouse_left   = 1'($urandom);
        mouse_right  = 1'($urandom);
        mouse_middle = 1'($urandom);
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [2:0] btn,
                        output int acc);
        int w;
        w            = 0;
        acc          = -1;
        pkt_valid    = 1'b1;
        mouse_x      = x;
        mouse_y      = y;
        mouse_middle = btn[2];
        mouse_right  = btn[1];
        mouse_left   = btn[0];
        while (acc < 0 && w < 3 * PLEN) begin
            @(negedge clk);
            if (pkt_ready === 1'b1) acc = ecnt + 1;
            @(posedge clk);
            #1;
            w++;
        end
        pkt_valid = 1'b0;
        scramble_inputs();
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout at cycle %0d: got no acceptance expected acceptance", ecnt);
        end
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (sched.size() != 0 && w < 4 * PLEN) begin
            @(negedge clk);
            w++;
        end
        if (sched.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout at cycle %0d: got %0d queued expected 0", name, ecnt,
                     sched.size());
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        repeat (98000) @(posedge clk);
        $display("FAIL watchdog at cycle %0d: got no end expected end", ecnt);
        $fatal(1, "watchdog expired");
    end

    int          acc_a, acc_b, acc_c, acc_d, acc_e, acc_f, acc_r, s_e;
    logic [39:0] lit, r_exp[2];

    initial begin
        reset     = 1'b1;
        pkt_valid = 1'b0;
        scramble_inputs();
        @(negedge clk);
        chk("reset_tx", uart_tx, 1'b1);
        chk("reset_ready", pkt_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

`ifdef MOUSE_TX_CHECKSUM_EN
        chk("model_pkt_a", mk(8'h05, 8'hFB, 3'b001), 40'hF7FB0509A5);
        chk("model_pkt_c", mk(8'hFF, 8'h80, 3'b100), 40'h7380FF0CA5);
`else
        chk("model_pkt_a", mk(8'h05, 8'hFB, 3'b001), 40'h00FB0509A5);
        chk("model_pkt_c", mk(8'hFF, 8'h80, 3'b100), 40'h0080FF0CA5);
`endif

        // Single packet from idle.
        send(8'h05, 8'hFB, 3'b001, acc_a);
        wait_idle("pkt_a");
        lit = mk(8'h05, 8'hFB, 3'b001);
        chk("a_byte_count", dq.size(), NB);
        chk("a_fall_latency", dq[0].st - acc_a, 2);
        chk("a_sync", dq[0].b, 8'hA5);
        chk("a_status", dq[1].b, 8'h09);
        chk("a_x", dq[2].b, 8'h05);
        chk("a_y", dq[3].b, 8'hFB);
`ifdef MOUSE_TX_CHECKSUM_EN
        chk("a_chk", dq[4].b, 8'hF7);
`endif
        dq.delete();

        // Back-to-back B and C, a withdrawn pulse while C is held, then D behind C.
        send(8'h01, 8'h02, 3'b000, acc_b);
        send(8'hFF, 8'h80, 3'b100, acc_c);
        // pkt_ready is back two cycles after B is taken; C is sampled on the next edge.
        chk("c_accept_delay", acc_c - acc_b, 3);
        repeat (20) @(posedge clk);
        #1;
        pkt_valid = 1'b1;
        mouse_x   = 8'h77;
        mouse_y   = 8'h66;
        repeat (3) @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        scramble_inputs();
        chk("held_ready_low", pkt_ready, 1'b0);
        send(8'h3C, 8'hC3, 3'b010, acc_d);
        chk("d_waits_for_c_load", acc_d > acc_b + PLEN, 1'b1);
        wait_idle("pkt_bcd");
        chk("bcd_byte_count", dq.size(), 3 * NB);
        chk("b_to_c_idle_cycles", dq[NB].st - dq[0].st - NB * 10 * CPB, 435);
        lit = 40'h0080FF0CA5;
`ifdef MOUSE_TX_CHECKSUM_EN
        lit[39:32] = 8'h73;
`endif
        for (int i = 0; i < NB; i++) chk("c_byte", dq[NB + i].b, lit[8 * i +: 8]);
        lit = mk(8'h3C, 8'hC3, 3'b010);
        for (int i = 0; i < NB; i++) chk("d_byte", dq[2 * NB + i].b, lit[8 * i +: 8]);
        dq.delete();

        // Reset during bit 3 of X (0x35 has a 0 there) with a second packet held.
        send(8'h35, 8'h11, 3'b011, acc_e);
        s_e = acc_e + 2;
        send(8'h22, 8'h33, 3'b001, acc_f);
        while (ecnt < s_e + 24 * CPB + CPB / 2) @(negedge clk);
        chk("pre_reset_tx", uart_tx, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_tx", uart_tx, 1'b1);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_ready", pkt_ready, 1'b1);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        dq.delete();
        @(posedge clk);
        #1;

        // Randomized packets with random spacing.
        for (int n = 0; n < 2; n++) begin
            logic [7:0] rx, ry;
            logic [2:0] rb;
            rx       = 8'($urandom);
            ry       = 8'($urandom);
            rb       = 3'($urandom);
            r_exp[n] = mk(rx, ry, rb);
            send(rx, ry, rb, acc_r);
            repeat ($urandom_range(0, 12 * CPB)) @(posedge clk);
            #1;
        end
        wait_idle("pkt_rand");
        chk("rand_byte_count", dq.size(), 2 * NB);
        for (int i = 0; i < 2 * NB; i++) chk("rand_byte", dq[i].b, r_exp[i / NB][8 * (i % NB) +: 8]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
